// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - boot, fetch, data and memory-side signal bundle for mem_arbiter
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              boot_active;
  logic              boot_wr;
  logic [DATA_W-1:0] boot_data;
  logic              boot_done;
  logic              boot_ovf;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack;
  logic              dm_rd;
  logic              dm_wr;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_ack;
  logic              stall;
  logic              mem_cs;
  logic              mem_we;
  logic              mem_oe;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  boot_active, boot_wr, boot_data, if_req, if_addr,
           dm_rd, dm_wr, dm_addr, dm_wdata, mem_rdata,
    output boot_done, boot_ovf, if_rdata, if_ack, dm_rdata, dm_ack,
           stall, mem_cs, mem_we, mem_oe, mem_addr, mem_wdata
  );

  modport master (
    output boot_active, boot_wr, boot_data, if_req, if_addr,
           dm_rd, dm_wr, dm_addr, dm_wdata, mem_rdata,
    input  boot_done, boot_ovf, if_rdata, if_ack, dm_rdata, dm_ack,
           stall, mem_cs, mem_we, mem_oe, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - boot/fetch/data sequencer for one shared single-port memory
module mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 1,
  parameter int BOOT_BASE   = 0,
  parameter int BOOT_WORDS  = 256
) (
  input  logic         clock,
  input  logic         reset,
  mem_arbiter_if.slave bus
);
  localparam int BC_W = $clog2(BOOT_WORDS + 1);
  localparam int LC_W = $clog2(MEM_LATENCY + 1);

  typedef enum logic [1:0] {S_BOOT = 2'd0, S_IDLE = 2'd1, S_ACCESS = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [BC_W-1:0]   boot_cnt_q, boot_cnt_d;
  logic [LC_W-1:0]   lat_cnt_q, lat_cnt_d;
  logic              last_data_q, last_data_d;
  logic              sel_data_q, sel_data_d;
  logic              op_wr_q, op_wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              if_ack_q, if_ack_d;
  logic              dm_ack_q, dm_ack_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              boot_done_q, boot_done_d;
  logic              boot_ovf_q, boot_ovf_d;

  logic              dm_req;
  logic              grant_data, grant_fetch;
  logic              mem_cs_c, mem_we_c, mem_oe_c;
  logic [ADDR_W-1:0] mem_addr_c;
  logic [DATA_W-1:0] mem_wdata_c;

  assign dm_req = bus.dm_rd | bus.dm_wr;

  always_comb begin
    state_d     = state_q;
    boot_cnt_d  = boot_cnt_q;
    lat_cnt_d   = lat_cnt_q;
    last_data_d = last_data_q;
    sel_data_d  = sel_data_q;
    op_wr_d     = op_wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    if_ack_d    = 1'b0;
    dm_ack_d    = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    boot_done_d = 1'b0;
    boot_ovf_d  = boot_ovf_q;
    grant_data  = 1'b0;
    grant_fetch = 1'b0;
    mem_cs_c    = 1'b1;
    mem_we_c    = 1'b0;
    mem_oe_c    = 1'b0;
    mem_addr_c  = '0;
    mem_wdata_c = '0;
    case (state_q)
      S_BOOT: begin
        if (!bus.boot_active) begin
          state_d     = S_IDLE;
          boot_done_d = 1'b1;
        end else if (bus.boot_wr) begin
          if (boot_cnt_q < BC_W'(BOOT_WORDS)) begin
            mem_cs_c    = 1'b0;
            mem_we_c    = 1'b1;
            mem_addr_c  = ADDR_W'(BOOT_BASE) + ADDR_W'(boot_cnt_q);
            mem_wdata_c = bus.boot_data;
            boot_cnt_d  = boot_cnt_q + 1'b1;
          end else begin
            boot_ovf_d  = 1'b1;
          end
        end
      end
      S_IDLE: begin
        // The ack cycle never grants: the acked master still holds its request here.
        if (!(if_ack_q | dm_ack_q)) begin
          grant_data  = dm_req & ~(bus.if_req & last_data_q);
          grant_fetch = bus.if_req & ~grant_data;
          if (grant_data | grant_fetch) begin
            state_d     = S_ACCESS;
            lat_cnt_d   = LC_W'(MEM_LATENCY);
            last_data_d = grant_data;
            sel_data_d  = grant_data;
            op_wr_d     = grant_data & bus.dm_wr;
            addr_d      = grant_data ? bus.dm_addr : bus.if_addr;
            wdata_d     = bus.dm_wdata;
          end
        end
      end
      S_ACCESS: begin
        mem_cs_c    = 1'b0;
        mem_we_c    = op_wr_q;
        mem_oe_c    = ~op_wr_q;
        mem_addr_c  = addr_q;
        mem_wdata_c = op_wr_q ? wdata_q : '0;
        if (lat_cnt_q == LC_W'(1)) begin
          state_d = S_IDLE;
          if (sel_data_q) begin
            dm_ack_d = 1'b1;
            if (!op_wr_q) dm_rdata_d = bus.mem_rdata;
          end else begin
            if_ack_d   = 1'b1;
            if_rdata_d = bus.mem_rdata;
          end
        end else begin
          lat_cnt_d = lat_cnt_q - 1'b1;
        end
      end
      default: state_d = S_BOOT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= S_BOOT;
      boot_cnt_q  <= '0;
      lat_cnt_q   <= '0;
      last_data_q <= 1'b0;
      sel_data_q  <= 1'b0;
      op_wr_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      boot_done_q <= 1'b0;
      boot_ovf_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      boot_cnt_q  <= boot_cnt_d;
      lat_cnt_q   <= lat_cnt_d;
      last_data_q <= last_data_d;
      sel_data_q  <= sel_data_d;
      op_wr_q     <= op_wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      if_ack_q    <= if_ack_d;
      dm_ack_q    <= dm_ack_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      boot_done_q <= boot_done_d;
      boot_ovf_q  <= boot_ovf_d;
    end
  end

  assign bus.mem_cs    = mem_cs_c;
  assign bus.mem_we    = mem_we_c;
  assign bus.mem_oe    = mem_oe_c;
  assign bus.mem_addr  = mem_addr_c;
  assign bus.mem_wdata = mem_wdata_c;
  assign bus.if_ack    = if_ack_q;
  assign bus.dm_ack    = dm_ack_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.boot_done = boot_done_q;
  assign bus.boot_ovf  = boot_ovf_q;
  assign bus.stall     = (state_q == S_BOOT) | (bus.if_req & ~if_ack_q) | (dm_req & ~dm_ack_q);
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized bench for mem_arbiter with a word-level memory reference model
module tb_mem_arbiter;
  localparam int LAT = 3;
  localparam int BW  = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MEM_LATENCY(LAT), .BOOT_BASE(0), .BOOT_WORDS(BW)
  ) u_dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  logic [31:0] sim_mem [0:255];
  logic [31:0] ref_mem [0:255];
  logic [31:0] exp_dm_rdata;
  bit          last_data;
  int          n_checks = 0;
  int          n_pass   = 0;

  assign bus.mem_rdata = bus.mem_oe ? sim_mem[bus.mem_addr[7:0]] : 32'h0;

  always @(posedge clock) begin
    if (!bus.mem_cs && bus.mem_we) sim_mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic do_xfer(input bit f, input bit d, input bit w, input bit r_too,
                         input logic [31:0] fa, input logic [31:0] da,
                         input logic [31:0] wd, input bit move_addr);
    bit pend_f, pend_d, first_seen, exp_first_data;
    int we_cyc, oe_cyc;
    pend_f = f; pend_d = d; first_seen = 0; we_cyc = 0; oe_cyc = 0;
    exp_first_data = d && !(f && last_data);
    bus.if_req   = f;
    bus.if_addr  = fa;
    bus.dm_rd    = d & (~w | r_too);
    bus.dm_wr    = d & w;
    bus.dm_addr  = da;
    bus.dm_wdata = wd;
    for (int c = 0; c < 8 * (LAT + 2) && (pend_f || pend_d); c++) begin
      @(negedge clock);
      if (!bus.mem_cs && bus.mem_we) we_cyc++;
      if (!bus.mem_cs && bus.mem_oe) oe_cyc++;
      if (bus.if_ack || bus.dm_ack) check_eq("ack_excl", {31'b0, bus.if_ack & bus.dm_ack}, 32'h0);
      else check_eq("stall_wait", {31'b0, bus.stall}, 32'h1);
      if (bus.if_ack) begin
        check_eq("if_ack_expected", {31'b0, pend_f}, 32'h1);
        check_eq("if_rdata", bus.if_rdata, ref_mem[fa[7:0]]);
        if (!first_seen) check_eq("order_first_data", 32'h0, {31'b0, exp_first_data});
        first_seen = 1; last_data = 0; pend_f = 0;
      end
      if (bus.dm_ack) begin
        check_eq("dm_ack_expected", {31'b0, pend_d}, 32'h1);
        if (w) begin
          ref_mem[da[7:0]] = wd;
          check_eq("dm_rdata_kept", bus.dm_rdata, exp_dm_rdata);
        end else begin
          exp_dm_rdata = ref_mem[da[7:0]];
          check_eq("dm_rdata", bus.dm_rdata, exp_dm_rdata);
        end
        if (!first_seen) check_eq("order_first_data", 32'h1, {31'b0, exp_first_data});
        first_seen = 1; last_data = 1; pend_d = 0;
      end
      @(posedge clock); #1;
      if (!pend_f) bus.if_req = 0;
      if (!pend_d) begin bus.dm_rd = 0; bus.dm_wr = 0; end
      if (move_addr) begin bus.dm_addr = da ^ 32'h45; bus.dm_wdata = ~wd; end
    end
    check_eq("xfer_done", {30'b0, pend_f, pend_d}, 32'h0);
    check_eq("we_cycles", we_cyc, (d && w) ? LAT : 0);
    check_eq("oe_cycles", oe_cyc, (f ? LAT : 0) + ((d && !w) ? LAT : 0));
  endtask

  task automatic count_boot_done(input int cycles, output int n);
    n = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clock);
      if (bus.boot_done) n++;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n, k;
    bit exp_is_data;
    logic [31:0] fa, da, wd;
    for (int i = 0; i < 256; i++) begin sim_mem[i] = 32'h0; ref_mem[i] = 32'h0; end
    exp_dm_rdata = 0; last_data = 0;
    bus.boot_active = 1; bus.boot_wr = 0; bus.boot_data = 0;
    bus.if_req = 0; bus.if_addr = 0; bus.dm_rd = 0; bus.dm_wr = 0;
    bus.dm_addr = 0; bus.dm_wdata = 0;

    repeat (2) @(posedge clock);
    @(negedge clock);
    check_eq("rst_mem_cs", {31'b0, bus.mem_cs}, 32'h1);
    check_eq("rst_mem_we", {31'b0, bus.mem_we}, 32'h0);
    check_eq("rst_mem_oe", {31'b0, bus.mem_oe}, 32'h0);
    check_eq("rst_mem_addr", bus.mem_addr, 32'h0);
    check_eq("rst_mem_wdata", bus.mem_wdata, 32'h0);
    check_eq("rst_acks", {30'b0, bus.if_ack, bus.dm_ack}, 32'h0);
    check_eq("rst_if_rdata", bus.if_rdata, 32'h0);
    check_eq("rst_dm_rdata", bus.dm_rdata, 32'h0);
    check_eq("rst_boot_flags", {30'b0, bus.boot_done, bus.boot_ovf}, 32'h0);
    check_eq("rst_stall", {31'b0, bus.stall}, 32'h1);
    @(posedge clock); #1;
    reset = 1;

    for (int i = 0; i < BW + 1; i++) begin
      bus.boot_wr = 1; bus.boot_data = 32'hA0 + i;
      @(negedge clock);
      if (i < BW) begin
        check_eq("boot_we", {31'b0, bus.mem_we}, 32'h1);
        check_eq("boot_cs", {31'b0, bus.mem_cs}, 32'h0);
        check_eq("boot_addr", bus.mem_addr, i);
        check_eq("boot_wdata", bus.mem_wdata, 32'hA0 + i);
        ref_mem[i] = 32'hA0 + i;
      end else begin
        check_eq("boot_drop_we", {31'b0, bus.mem_we}, 32'h0);
      end
      @(posedge clock); #1;
    end
    bus.boot_wr = 0;
    @(negedge clock);
    check_eq("boot_ovf_set", {31'b0, bus.boot_ovf}, 32'h1);
    @(posedge clock); #1;
    bus.boot_active = 0;
    count_boot_done(4, n);
    check_eq("boot_done_pulses", n, 1);
    check_eq("boot_ovf_sticky", {31'b0, bus.boot_ovf}, 32'h1);
    check_eq("idle_stall", {31'b0, bus.stall}, 32'h0);
    @(posedge clock); #1;
    bus.boot_active = 1; bus.boot_wr = 1; bus.boot_data = 32'hBAD;
    @(negedge clock);
    check_eq("late_boot_ignored", {31'b0, bus.mem_we}, 32'h0);
    @(posedge clock); #1;
    bus.boot_active = 0; bus.boot_wr = 0;

    do_xfer(1, 0, 0, 0, 32'h2, 32'h0, 32'h0, 0);
    do_xfer(0, 1, 1, 0, 32'h0, 32'h10, 32'hDEAD, 1);
    do_xfer(0, 1, 0, 0, 32'h0, 32'h10, 32'h0, 0);
    do_xfer(0, 1, 0, 0, 32'h0, 32'h55, 32'h0, 0);
    do_xfer(0, 1, 1, 1, 32'h0, 32'h20, 32'hBEEF, 0);

    // Both masters held continuously: grants must alternate.
    bus.if_req = 1; bus.if_addr = 3; bus.dm_rd = 1; bus.dm_addr = 1;
    k = 0;
    for (int c = 0; c < 60 && k < 4; c++) begin
      @(negedge clock);
      if (bus.if_ack || bus.dm_ack) begin
        exp_is_data = !last_data;
        check_eq("alt_excl", {31'b0, bus.if_ack & bus.dm_ack}, 32'h0);
        check_eq("alt_kind", {31'b0, bus.dm_ack}, {31'b0, exp_is_data});
        if (bus.dm_ack) begin
          exp_dm_rdata = ref_mem[1];
          check_eq("alt_dm_rdata", bus.dm_rdata, exp_dm_rdata);
        end else begin
          check_eq("alt_if_rdata", bus.if_rdata, ref_mem[3]);
        end
        last_data = exp_is_data;
        k++;
      end
      @(posedge clock); #1;
    end
    check_eq("alt_count", k, 4);
    bus.if_req = 0; bus.dm_rd = 0;

    for (int it = 0; it < 24; it++) begin
      n  = $urandom_range(0, 3);
      fa = $urandom_range(0, 31);
      da = $urandom_range(0, 31);
      wd = $urandom;
      case (n)
        0: do_xfer(1, 0, 0, 0, fa, da, wd, 0);
        1: do_xfer(0, 1, 0, 0, fa, da, wd, 0);
        2: do_xfer(0, 1, 1, ($urandom_range(0, 3) == 0), fa, da, wd, 0);
        default: do_xfer(1, 1, $urandom_range(0, 1) == 1, 0, fa, da, wd, 0);
      endcase
    end

    bus.dm_rd = 1; bus.dm_addr = 5;
    @(negedge clock);
    @(posedge clock); #1;
    reset = 0;
    @(negedge clock);
    check_eq("abort_in_access", {31'b0, bus.mem_cs}, 32'h0);
    @(negedge clock);
    check_eq("abort_mem_cs", {31'b0, bus.mem_cs}, 32'h1);
    check_eq("abort_mem_oe", {31'b0, bus.mem_oe}, 32'h0);
    check_eq("abort_dm_ack", {31'b0, bus.dm_ack}, 32'h0);
    check_eq("abort_dm_rdata", bus.dm_rdata, 32'h0);
    check_eq("abort_boot_ovf", {31'b0, bus.boot_ovf}, 32'h0);
    check_eq("abort_stall", {31'b0, bus.stall}, 32'h1);
    @(posedge clock); #1;
    bus.dm_rd = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      check_eq("abort_no_ack", {31'b0, bus.dm_ack}, 32'h0);
    end
    exp_dm_rdata = 0; last_data = 0;
    @(posedge clock); #1;
    bus.boot_active = 0; reset = 1;
    count_boot_done(4, n);
    check_eq("reboot_done_pulses", n, 1);
    @(posedge clock); #1;
    do_xfer(1, 0, 0, 0, 32'h10, 32'h0, 32'h0, 0);
    do_xfer(0, 1, 0, 0, 32'h0, 32'h3, 32'h0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
